// File: rtl/user_mem_arbiter.sv
// Two-master round-robin arbiter in front of the pipelined user-project memory.
// One transaction outstanding at a time, a forced stb-low drain gap after each one, and a timeout error.
module user_mem_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int DRAIN   = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_stb,
    input  logic        m1_stb,
    input  logic        m0_we,
    input  logic        m1_we,
    input  logic [3:0]  m0_sel,
    input  logic [3:0]  m1_sel,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m0_dat_i,
    input  logic [31:0] m1_dat_i,
    output logic        m0_ack,
    output logic        m1_ack,
    output logic        m0_err,
    output logic        m1_err,
    output logic [31:0] m_dat_o,
    output logic        s_stb,
    output logic        s_we,
    output logic [3:0]  s_sel,
    output logic [31:0] s_addr,
    output logic [31:0] s_dat_o,
    input  logic        s_ack,
    input  logic [31:0] s_dat_i,
    output logic [1:0]  gnt
);

    localparam int CNT_MAX = (TIMEOUT > DRAIN) ? TIMEOUT : DRAIN;
    localparam int CW      = $clog2(CNT_MAX) + 1;

    localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN - 1);
    localparam logic [CW-1:0] CNT_SAT    = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          last_gnt_q, last_gnt_d;   // 1 = master 1 was served last
    logic [1:0]    gnt_q, gnt_d;
    logic [1:0]    err_q, err_d;
    logic          s_stb_q, s_stb_d;
    logic          s_we_q, s_we_d;
    logic [3:0]    s_sel_q, s_sel_d;
    logic [31:0]   s_addr_q, s_addr_d;
    logic [31:0]   s_dat_q, s_dat_d;

    logic any_req, pick_m1, busy, timeout, drain_done;

    assign any_req    = m0_stb | m1_stb;
    assign pick_m1    = m1_stb & (~m0_stb | ~last_gnt_q);
    assign busy       = (state_q == ST_BUSY);
    assign timeout    = busy & (cnt_q == TO_LAST);
    assign drain_done = (state_q == ST_DRAIN) & (cnt_q == DRAIN_LAST);
    assign cnt_inc    = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CW'(1);

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            last_gnt_q <= 1'b1;
            gnt_q      <= 2'b00;
            err_q      <= 2'b00;
            s_stb_q    <= 1'b0;
            s_we_q     <= 1'b0;
            s_sel_q    <= 4'h0;
            s_addr_q   <= 32'h0;
            s_dat_q    <= 32'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_gnt_q <= last_gnt_d;
            gnt_q      <= gnt_d;
            err_q      <= err_d;
            s_stb_q    <= s_stb_d;
            s_we_q     <= s_we_d;
            s_sel_q    <= s_sel_d;
            s_addr_q   <= s_addr_d;
            s_dat_q    <= s_dat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (any_req) state_d = ST_BUSY;
            ST_BUSY:  if (s_ack || timeout) state_d = ST_DRAIN;
            ST_DRAIN: if (drain_done) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        cnt_d      = cnt_q;
        last_gnt_d = last_gnt_q;
        gnt_d      = gnt_q;
        err_d      = 2'b00;
        s_stb_d    = s_stb_q;
        s_we_d     = s_we_q;
        s_sel_d    = s_sel_q;
        s_addr_d   = s_addr_q;
        s_dat_d    = s_dat_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (any_req) begin
                    gnt_d    = {pick_m1, ~pick_m1};
                    s_stb_d  = 1'b1;
                    s_we_d   = pick_m1 ? m1_we    : m0_we;
                    s_sel_d  = pick_m1 ? m1_sel   : m0_sel;
                    s_addr_d = pick_m1 ? m1_addr  : m0_addr;
                    s_dat_d  = pick_m1 ? m1_dat_i : m0_dat_i;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_inc;
                // An ack in the timeout cycle still completes the transaction normally.
                if (s_ack) begin
                    last_gnt_d = gnt_q[1];
                    cnt_d      = '0;
                    gnt_d      = 2'b00;
                    s_stb_d    = 1'b0;
                end else if (timeout) begin
                    err_d   = gnt_q;
                    cnt_d   = '0;
                    gnt_d   = 2'b00;
                    s_stb_d = 1'b0;
                end
            end
            ST_DRAIN: cnt_d = cnt_inc;
            default:  cnt_d = '0;
        endcase
    end

    // A master that dropped stb mid-transaction gets no ack, though the slave side still completes.
    assign m0_ack  = s_ack & busy & gnt_q[0] & m0_stb;
    assign m1_ack  = s_ack & busy & gnt_q[1] & m1_stb;
    assign m0_err  = err_q[0];
    assign m1_err  = err_q[1];
    assign m_dat_o = s_dat_i;
    assign s_stb   = s_stb_q;
    assign s_we    = s_we_q;
    assign s_sel   = s_sel_q;
    assign s_addr  = s_addr_q;
    assign s_dat_o = s_dat_q;
    assign gnt     = gnt_q;

endmodule
